// File: rtl/alu_defs.sv
// alu_defs: ALU function codes and fxmul_seq state encoding
package alu_defs;
    localparam logic [4:0] ALU_ADD = 5'b00001;
    localparam logic [4:0] ALU_SUB = 5'b10001;
    typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, MUL, FIX, DONE} fx_state_t;
endpackage

// File: rtl/fx_saturate.sv
// fx_saturate: extracts the QF magnitude from the product and flags/saturates overflow
module fx_saturate #(
    parameter int N = 32,
    parameter int F = 28
) (
    input  logic [2*N-F-1:0] p_top,
    input  logic             sign,
    output logic [N-1:0]     m,
    output logic             overflow_n,
    output logic [N-1:0]     sat
);
    // p_top is the product with its F discarded fraction bits already dropped
    assign m          = p_top[N-1:0];
    assign overflow_n = |p_top[2*N-F-1:N-1];
    assign sat        = sign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
endmodule

// File: rtl/fxmul_seq.sv
// fxmul_seq: sequential signed fixed-point shift-and-add multiplier using an external ALU adder
module fxmul_seq
    import alu_defs::*;
#(
    parameter int N = 32,
    parameter int F = 28
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [4:0]   alu_fn,
    input  logic [N-1:0] alu_r
);
    localparam int SW = $clog2(N);

    fx_state_t    state, next;
    logic [N-1:0] a_reg, b_reg, mag_a, hi, lo, m, sat;
    logic         sign, ovf_n;
    logic [SW-1:0] step;

    fx_saturate #(.N(N), .F(F)) u_sat (
        .p_top     ({hi, lo[N-1:F]}),
        .sign      (sign),
        .m         (m),
        .overflow_n(ovf_n),
        .sat       (sat)
    );

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    // Next-state decode and ALU operand steering
    always_comb begin
        next   = state;
        alu_fn = ALU_ADD;
        alu_a  = '0;
        alu_b  = '0;
        case (state)
            IDLE:    next = start ? ABS_A : IDLE;
            ABS_A: begin
                alu_fn = ALU_SUB;
                alu_b  = a_reg;
                next   = ABS_B;
            end
            ABS_B: begin
                alu_fn = ALU_SUB;
                alu_b  = b_reg;
                next   = MUL;
            end
            MUL: begin
                alu_a = hi;
                alu_b = lo[0] ? mag_a : '0;
                next  = (step == SW'(N-1)) ? FIX : MUL;
            end
            FIX: begin
                alu_fn = ALU_SUB;
                alu_b  = m;
                next   = DONE;
            end
            default: next = IDLE;
        endcase
    end

    // State and datapath registers; the ALU result is consumed in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            sign     <= 1'b0;
            mag_a    <= '0;
            hi       <= '0;
            lo       <= '0;
            step     <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= next;
            case (state)
                IDLE: if (start) begin
                    a_reg <= a;
                    b_reg <= b;
                    sign  <= a[N-1] ^ b[N-1];
                end
                ABS_A: mag_a <= a_reg[N-1] ? alu_r : a_reg;
                ABS_B: begin
                    hi   <= '0;
                    lo   <= b_reg[N-1] ? alu_r : b_reg;
                    step <= '0;
                end
                MUL: begin
                    hi   <= {1'b0, alu_r[N-1:1]};
                    lo   <= {alu_r[0], lo[N-1:1]};
                    step <= step + 1'b1;
                end
                FIX: begin
                    result   <= ovf_n ? sat : (sign ? alu_r : m);
                    overflow <= ovf_n;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fxmul_seq.sv
// tb_fxmul_seq: scoreboard bench for fxmul_seq with a behavioural ALU
module tb_fxmul_seq;
    logic        clk = 0, reset = 1, start = 0;
    logic [31:0] a = 0, b = 0, result, alu_a, alu_b, alu_r;
    logic [4:0]  alu_fn;
    logic        busy, done, overflow;

    typedef struct {
        logic [31:0] r;
        logic        o;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0, checks = 0, passes = 0, done_cnt = 0;

    fxmul_seq #(.N(32), .F(28)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_r(alu_r)
    );

    assign alu_r = (alu_fn == 5'b10001) ? alu_a - alu_b : alu_a + alu_b;

    always #5 clk = ~clk;

    // cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [32:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        logic [31:0] ma, mb;
        logic [63:0] q;
        s  = x[31] ^ y[31];
        ma = x[31] ? -x : x;
        mb = y[31] ? -y : y;
        q  = (64'(ma) * 64'(mb)) >> 28;
        if (q >= 64'h80000000) return {1'b1, s ? 32'h80000000 : 32'h7FFFFFFF};
        return {1'b0, s ? -q[31:0] : q[31:0]};
    endfunction

    // monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: result %h overflow %b, no pending request", result, overflow);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e.r);
                check("overflow", {31'b0, overflow}, {31'b0, e.o});
                check("latency", 32'(cyc - e.c - 1), 32'd35);
            end
        end
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic eo, input bit push);
        int t = 0;
        while ((busy || done) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            $display("FAIL issue_timeout: busy %b done %b after %0d cycles", busy, done, t);
        end
        a = x;
        b = y;
        start = 1;
        if (push) exp_q.push_back('{r: er, o: eo, c: cyc});
        @(negedge clk);
        start = 0;
    endtask

    task automatic issue_ref(input logic [31:0] x, input logic [31:0] y);
        logic [32:0] r;
        r = ref_mul(x, y);
        issue(x, y, r[31:0], r[32], 1);
    endtask

    initial begin
        int d0, t;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_overflow", {31'b0, overflow}, 32'd0);
        check("idle_alu_fn", {27'b0, alu_fn}, 32'd1);
        check("idle_alu_a", alu_a, 32'd0);
        check("idle_alu_b", alu_b, 32'd0);

        issue(32'h18000000, 32'h20000000, 32'h30000000, 0, 1);
        issue(32'hE8000000, 32'h20000000, 32'hD0000000, 0, 1);
        issue(32'hE8000000, 32'hE0000000, 32'h30000000, 0, 1);
        issue(32'h40000000, 32'h40000000, 32'h7FFFFFFF, 1, 1);
        issue(32'h80000000, 32'h10000000, 32'h80000000, 1, 1);
        issue(32'h00000001, 32'h00000001, 32'h00000000, 0, 1);
        issue(32'h08000000, 32'hF8000000, 32'hFC000000, 0, 1);
        issue(32'h00000000, 32'hF0000000, 32'h00000000, 0, 1);
        issue(32'h80000000, 32'h80000000, 32'h7FFFFFFF, 1, 1);

        // starts while busy must be ignored
        issue(32'h18000000, 32'h20000000, 32'h30000000, 0, 1);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        a = 32'h40000000; b = 32'h40000000; start = 1;
        @(negedge clk); start = 0;
        repeat (14) @(negedge clk);
        a = 32'h80000000; b = 32'h10000000; start = 1;
        @(negedge clk); start = 0;
        repeat (40) @(negedge clk);
        check("ignored_start_dones", 32'(done_cnt - d0), 32'd1);
        check("ignored_start_result_held", result, 32'h30000000);
        check("ignored_start_busy", {31'b0, busy}, 32'd0);

        // reset in the middle of an operation
        issue(32'h18000000, 32'h20000000, 32'h0, 0, 0);
        repeat (9) @(negedge clk);
        d0 = done_cnt;
        reset = 1;
        #1;
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_done", {31'b0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_alu_fn", {27'b0, alu_fn}, 32'd1);
        @(negedge clk);
        reset = 0;
        repeat (40) @(negedge clk);
        check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
        issue(32'hE8000000, 32'hE0000000, 32'h30000000, 0, 1);

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            x = 32'($signed(x) >>> $urandom_range(0, 5));
            y = 32'($signed(y) >>> $urandom_range(0, 5));
            issue_ref(x, y);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d results never arrived", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
